// File: rtl/serial_subtractor.sv
// Bit-serial subtractor D = A - B - Bin, LSB first, one bit per clock, start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the two's-complement overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
`ifdef SERIAL_SUB_OVF_EN
  , output logic           ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             accept, last, d_bit, br_nxt;

  assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
  assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On the final edge a_sh[0]/b_sh[0] hold the captured MSBs of A and B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh <= '0;
      b_sh <= '0;
      r_sh <= '0;
      br   <= 1'b0;
      cnt  <= '0;
      D    <= '0;
      Bout <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf  <= 1'b0;
`endif
    end else if (accept) begin
      a_sh <= A;
      b_sh <= B;
      br   <= Bin;
      cnt  <= '0;
    end else if (state == RUN) begin
      a_sh <= a_sh >> 1;
      b_sh <= b_sh >> 1;
      r_sh <= {d_bit, r_sh[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + 1'b1;
      if (last) begin
        D    <= {d_bit, r_sh[WIDTH-1:1]};
        Bout <= br_nxt;
`ifdef SERIAL_SUB_OVF_EN
        ovf  <= (a_sh[0] ^ b_sh[0]) & (d_bit ^ a_sh[0]);
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor (WIDTH=8): directed vectors, monitor pops on done.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0, B = '0;
  logic         Bin = 1'b0;
  logic         ready, busy, done, Bout;
  logic [W-1:0] D;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Bin(Bin),
    .ready(ready), .busy(busy), .done(done), .D(D), .Bout(Bout)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           acc;
    string        name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                       input logic [W-1:0] d, input logic bo, input logic ov, input string nm);
    int n = 0;
    exp_t e;
    while (!ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!ready) begin
      chk({nm, "_ready_timeout"}, 32'(ready), 32'd1);
      return;
    end
    A = a; B = b; Bin = bin; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    A = ~a; B = ~b; Bin = ~bin;
    e.d = d; e.bout = bo; e.ovf = ov; e.acc = cyc; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic wait_empty(input string nm);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drain"}, 32'(sb.size()), 32'd0);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'd0);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_D"}, 32'(D), 32'(e.d));
          chk({e.name, "_Bout"}, 32'(Bout), 32'(e.bout));
          chk({e.name, "_latency"}, 32'(cyc - e.acc), 32'(W));
          chk({e.name, "_ready"}, 32'(ready), 32'd1);
          chk({e.name, "_busy"}, 32'(busy), 32'd0);
`ifdef SERIAL_SUB_OVF_EN
          chk({e.name, "_ovf"}, 32'(ovf), 32'(e.ovf));
`endif
          @(negedge clk);
          chk({e.name, "_done_1cyc"}, 32'(done), 32'd0);
        end
      end
    end
  end

  initial begin
    bit seen_done;
    #3;
    chk("rst_D", 32'(D), 32'd0);
    chk("rst_Bout", 32'(Bout), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "v05_03");
    chk("run_busy", 32'(busy), 32'd1);
    chk("run_ready", 32'(ready), 32'd0);
    wait_empty("v05_03");
    issue(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, "v00_01");
    wait_empty("v00_01");
    issue(8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0, "v10_0F");
    wait_empty("v10_0F");
    issue(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "v80_01");
    wait_empty("v80_01");
    issue(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, "v7F_01");
    wait_empty("v7F_01");

    // Start during RUN must be ignored.
    issue(8'h3C, 8'hC3, 1'b0, 8'h79, 1'b1, 1'b0, "v3C_C3");
    repeat (2) @(negedge clk);
    A = 8'h11; B = 8'h22; Bin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_empty("v3C_C3");
    repeat (3) @(negedge clk);
    chk("idle_after_ignore", 32'(busy), 32'd0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, "bb1");
    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "bb2");
    wait_empty("bb");

    // Reset mid-RUN aborts with no done.
    issue(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, "abort");
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("abort_D", 32'(D), 32'd0);
    chk("abort_Bout", 32'(Bout), 32'd0);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    seen_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    chk("abort_no_done", 32'(seen_done), 32'd0);
    chk("abort_idle_ready", 32'(ready), 32'd1);

    issue(8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1, "post_rst");
    wait_empty("post_rst");
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
